bt_pipe_out_source: RTL and testbench

Block-throttled pipe-out data source: generates a selectable 32-bit test pattern, buffers it in an internal FIFO, and presents it to a block-throttled pipe-out endpoint. `pipe_out_ready` is raised only when at least one full block is buffered. It is the transmit-side counterpart of the pipe-in checker and runs in the host-interface clock domain (okClk). It stress-tests host reads with deterministic, host-reproducible data and reports underflows.

---
 rtl/bt_pipe_pkg.sv | 45 ++++
 rtl/bt_word_fifo.sv | 55 +++++
 rtl/bt_pipe_out_source.sv | 138 +++++++++++++
 tb/tb_bt_pipe_out_source.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bt_pipe_pkg.sv
// Shared types and constants for the block-throttled pipe-out source.
// FSM states, pattern codes, generator constants and next-value helpers.
package bt_pipe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_READY,
      ST_BURST
   } state_t;

   localparam logic [2:0]  PAT_CNT   = 3'd0;
   localparam logic [2:0]  PAT_LFSR  = 3'd1;
   localparam logic [2:0]  PAT_WALK  = 3'd2;
   localparam logic [2:0]  PAT_ALT   = 3'd3;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
   localparam logic [31:0] UF_WORD   = 32'hDEAD_DEAD;
   localparam logic [31:0] ALT_A     = 32'hAAAA_5555;
   localparam logic [31:0] ALT_B     = 32'h5555_AAAA;

   function automatic logic [31:0] gen_start(
      input logic [2:0]  pat,
      input logic [31:0] seed
   );
      case (pat)
         PAT_LFSR: gen_start = seed;
         PAT_ALT:  gen_start = ALT_A;
         default:  gen_start = 32'h1;
      endcase
   endfunction

   function automatic logic [31:0] gen_next(
      input logic [2:0]  pat,
      input logic [31:0] g
   );
      case (pat)
         PAT_LFSR: gen_next = g[0] ? ((g >> 1) ^ LFSR_MASK) : (g >> 1);
         PAT_WALK: gen_next = {g[30:0], g[31]};
         PAT_ALT:  gen_next = (g == ALT_A) ? ALT_B : ALT_A;
         default:  gen_next = g + 32'd1;
      endcase
   endfunction

endpackage

// File: rtl/bt_word_fifo.sv
// Synchronous word FIFO with level output, registered read data and
// synchronous flush.
module bt_word_fifo #(
   parameter int DEPTH = 512,
   parameter int W     = 32,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_flush,
   input  logic          i_wr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_rd,
   output logic [W-1:0]  o_rdata,
   output logic [LW-1:0] o_level,
   output logic          o_full,
   output logic          o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         w_wr;
   logic         w_rd;

   assign o_level = LW'(r_wptr - r_rptr);
   assign o_full  = (o_level == LW'(DEPTH));
   assign o_empty = (o_level == '0);
   assign w_wr    = i_wr & ~o_full;
   assign w_rd    = i_rd & ~o_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         o_rdata <= '0;
      end else begin
         if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
         end
         if (w_rd) o_rdata <= r_mem[r_rptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/bt_pipe_out_source.sv
// Block-throttled pipe-out test-pattern source (okClk domain).
// Define BT_PIPE_SRC_STATS_EN to build the underflow/words-sent counters.
module bt_pipe_out_source
   import bt_pipe_pkg::*;
#(
   parameter int          BLOCK_WORDS = 256,
   parameter int          FIFO_DEPTH  = 512,
   parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [2:0]  pattern,
   input  logic        throttle_set,
   input  logic [31:0] throttle_val,
   input  logic        pipe_out_read,
   input  logic        pipe_out_blockstrobe,
   output logic [31:0] pipe_out_data,
   output logic        pipe_out_ready,
   output logic [31:0] underflow_count,
   output logic [31:0] words_sent
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(BLOCK_WORDS) + 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_en_q;
   logic [2:0]      r_pat;
   logic [31:0]     r_thr;
   logic [31:0]     r_gen;
   logic [BW-1:0]   r_bcnt;
   logic            r_ready;
   logic            r_uf;

   logic [LW-1:0]   w_level;
   logic            w_full;
   logic            w_empty;
   logic [31:0]     w_fifo_data;
   logic            w_wr;
   logic            w_flush;
   logic            w_rise;
   logic            w_blk_ok;
   logic            w_last;

   assign w_flush  = (r_state == ST_IDLE);
   assign w_wr     = ~w_flush & r_thr[0] & ~w_full;
   assign w_rise   = enable & ~r_en_q;
   assign w_blk_ok = (w_level >= LW'(BLOCK_WORDS));
   assign w_last   = pipe_out_read && (r_bcnt == BW'(BLOCK_WORDS - 1));

   bt_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32),
      .LW    (LW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (w_flush),
      .i_wr    (w_wr),
      .i_wdata (r_gen),
      .i_rd    (pipe_out_read),
      .o_rdata (w_fifo_data),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE:  if (w_rise) w_state_nxt = ST_PRIME;
            ST_PRIME: if (w_blk_ok) w_state_nxt = ST_READY;
            ST_READY: if (pipe_out_blockstrobe) w_state_nxt = ST_BURST;
            ST_BURST: if (w_last) w_state_nxt = w_blk_ok ? ST_READY : ST_PRIME;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // A fresh enable edge is required after reset, so the edge detector
   // comes out of reset as if enable had been high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_en_q  <= 1'b1;
         r_pat   <= PAT_CNT;
         r_thr   <= 32'hFFFF_FFFF;
         r_gen   <= LFSR_SEED;
         r_bcnt  <= '0;
         r_ready <= 1'b0;
         r_uf    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_en_q  <= enable;
         r_ready <= (w_state_nxt == ST_READY);
         if (r_state == ST_IDLE && w_rise) r_pat <= pattern;
         if (throttle_set) r_thr <= throttle_val;
         else              r_thr <= {r_thr[30:0], r_thr[31]};
         if (r_state == ST_IDLE) r_gen <= gen_start(pattern, LFSR_SEED);
         else if (w_wr)          r_gen <= gen_next(r_pat, r_gen);
         if (r_state == ST_READY && pipe_out_blockstrobe)
            r_bcnt <= '0;
         else if (r_state == ST_BURST && pipe_out_read)
            r_bcnt <= r_bcnt + BW'(1);
         if (pipe_out_read) r_uf <= w_empty;
      end
   end

   assign pipe_out_data  = r_uf ? UF_WORD : w_fifo_data;
   assign pipe_out_ready = r_ready;

`ifdef BT_PIPE_SRC_STATS_EN
   logic [31:0] r_uf_cnt;
   logic [31:0] r_ws_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_uf_cnt <= '0;
         r_ws_cnt <= '0;
      end else if (pipe_out_read) begin
         if (!w_empty)                      r_ws_cnt <= r_ws_cnt + 32'd1;
         else if (r_uf_cnt != 32'hFFFF_FFFF) r_uf_cnt <= r_uf_cnt + 32'd1;
      end
   end

   assign underflow_count = r_uf_cnt;
   assign words_sent      = r_ws_cnt;
`else
   assign underflow_count = '0;
   assign words_sent      = '0;
`endif

endmodule

// File: tb/tb_bt_pipe_out_source.sv
// Directed self-checking bench for bt_pipe_out_source.
// Expected counter values follow BT_PIPE_SRC_STATS_EN.
module tb_bt_pipe_out_source;

`ifdef BT_PIPE_SRC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [2:0]  pattern;
   logic        throttle_set;
   logic [31:0] throttle_val;
   logic        pipe_out_read;
   logic        pipe_out_blockstrobe;
   logic [31:0] pipe_out_data;
   logic        pipe_out_ready;
   logic [31:0] underflow_count;
   logic [31:0] words_sent;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bt_pipe_out_source #(
      .BLOCK_WORDS (256),
      .FIFO_DEPTH  (512),
      .LFSR_SEED   (32'h0000_0001)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .enable               (enable),
      .pattern              (pattern),
      .throttle_set         (throttle_set),
      .throttle_val         (throttle_val),
      .pipe_out_read        (pipe_out_read),
      .pipe_out_blockstrobe (pipe_out_blockstrobe),
      .pipe_out_data        (pipe_out_data),
      .pipe_out_ready       (pipe_out_ready),
      .underflow_count      (underflow_count),
      .words_sent           (words_sent)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Reference generator: 0 counter, 1 LFSR, 2 walking one,
   // 3 alternating, 15 constant, others counter.
   function automatic logic [31:0] mdl_next(input logic [3:0] p,
                                            input logic [31:0] g);
      case (p)
         4'd1:    mdl_next = g[0] ? ((g >> 1) ^ 32'h8020_0003) : (g >> 1);
         4'd2:    mdl_next = {g[30:0], g[31]};
         4'd3:    mdl_next = ~g;
         4'd15:   mdl_next = g;
         default: mdl_next = g + 32'd1;
      endcase
   endfunction

   // Called at a negedge; returns at a negedge once ready is seen.
   task automatic restart(input logic [2:0] pat, input logic [31:0] thr,
                          input int exp_lat, input string tag);
      int n;
      enable       = 1'b0;
      throttle_set = 1'b1;
      throttle_val = thr;
      @(negedge clk);
      throttle_set = 1'b0;
      pattern      = pat;
      enable       = 1'b1;
      n = 0;
      while (n <= exp_lat + 64) begin
         @(negedge clk);
         n++;
         if (pipe_out_ready) break;
      end
      chk(tag, n, exp_lat);
   endtask

   task automatic strobe(input string tag);
      pipe_out_blockstrobe = 1'b1;
      @(negedge clk);
      pipe_out_blockstrobe = 1'b0;
      chk(tag, {31'd0, pipe_out_ready}, 32'd0);
   endtask

   task automatic read_seq(input int cnt, input logic [3:0] p,
                           input logic [31:0] g0, output logic [31:0] g1,
                           input string tag);
      logic [31:0] g;
      g = g0;
      pipe_out_read = 1'b1;
      for (int i = 0; i < cnt; i++) begin
         @(negedge clk);
         if (i == cnt - 1) pipe_out_read = 1'b0;
         chk(tag, pipe_out_data, g);
         g = mdl_next(p, g);
      end
      g1 = g;
   endtask

   initial begin
      logic [31:0] g;
      reset_n              = 1'b0;
      enable               = 1'b1;
      pattern              = 3'd0;
      throttle_set         = 1'b0;
      throttle_val         = 32'd0;
      pipe_out_read        = 1'b0;
      pipe_out_blockstrobe = 1'b0;

      #12;
      chk("rst_data", pipe_out_data, 32'd0);
      chk("rst_ready", {31'd0, pipe_out_ready}, 32'd0);
      chk("rst_uf", underflow_count, 32'd0);
      chk("rst_ws", words_sent, 32'd0);

      @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("no_fresh_edge", {31'd0, pipe_out_ready}, 32'd0);

      restart(3'd0, 32'hFFFF_FFFF, 258, "cnt_ready_lat");
      strobe("cnt_burst_ready");
      read_seq(256, 4'd0, 32'd1, g, "cnt_data");
      chk("cnt_ready_again", {31'd0, pipe_out_ready}, 32'd1);
      chk("cnt_ws", words_sent, STATS ? 32'd256 : 32'd0);

      restart(3'd2, 32'hFFFF_FFFF, 258, "walk_ready_lat");
      read_seq(4, 4'd2, 32'd1, g, "walk_data");
      restart(3'd3, 32'hFFFF_FFFF, 258, "alt_ready_lat");
      read_seq(4, 4'd3, 32'hAAAA_5555, g, "alt_data");
      restart(3'd5, 32'hFFFF_FFFF, 258, "pat5_ready_lat");
      read_seq(3, 4'd5, 32'd1, g, "pat5_data");

      restart(3'd1, 32'hFFFF_FFFF, 258, "lfsr_ready_lat");
      g = 32'd1;
      for (int b = 0; b < 3; b++) begin
         strobe("lfsr_burst_ready");
         read_seq(256, 4'd1, g, g, "lfsr_data");
         chk("lfsr_ready_after", {31'd0, pipe_out_ready}, 32'd1);
      end

      // Freeze the generator with 258 words buffered, drain 248 in READY,
      // then burst across the empty point.
      restart(3'd0, 32'hFFFF_FFFF, 258, "uf_ready_lat");
      throttle_set = 1'b1;
      throttle_val = 32'd0;
      @(negedge clk);
      throttle_set = 1'b0;
      read_seq(248, 4'd0, 32'd1, g, "uf_pre_data");
      chk("uf_ready_held", {31'd0, pipe_out_ready}, 32'd1);
      strobe("uf_burst_ready");
      read_seq(10, 4'd0, 32'd249, g, "uf_tail_data");
      read_seq(10, 4'd15, 32'hDEAD_DEAD, g, "uf_dead_data");
      chk("uf_count", underflow_count, STATS ? 32'd10 : 32'd0);
      repeat (3) @(negedge clk);
      chk("uf_data_hold", pipe_out_data, 32'hDEAD_DEAD);

      restart(3'd0, 32'h0000_0001, 8194, "thr_ready_lat");

      restart(3'd0, 32'hFFFF_FFFF, 258, "dis_ready_lat");
      strobe("dis_burst_ready");
      read_seq(100, 4'd0, 32'd1, g, "dis_data");
      enable = 1'b0;
      repeat (2) @(negedge clk);
      chk("dis_ready_low", {31'd0, pipe_out_ready}, 32'd0);
      restart(3'd0, 32'hFFFF_FFFF, 258, "reen_ready_lat");
      strobe("reen_burst_ready");
      read_seq(5, 4'd0, 32'd1, g, "reen_data");

      pipe_out_read = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_data", pipe_out_data, 32'd0);
      chk("arst_ready", {31'd0, pipe_out_ready}, 32'd0);
      chk("arst_uf", underflow_count, 32'd0);
      chk("arst_ws", words_sent, 32'd0);
      pipe_out_read = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("arst_no_restart", {31'd0, pipe_out_ready}, 32'd0);
      chk("arst_data_after", pipe_out_data, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
